// File: rtl/ex_ls_pkg.sv
// Shared types, LS op encodings and width/extension helpers
// for the load/store execution unit.
package ex_ls_pkg;

    typedef logic [31:0] word_t;
    typedef logic [4:0]  regtag_t;
    typedef logic [4:0]  regaddr_t;
    typedef logic [3:0]  sinst_t;

    // Tag value meaning "operand data is valid".
    localparam regtag_t UNLOCKED = 5'h10;

    localparam word_t LS_IO_BASE = 32'h0003_0000;

    localparam sinst_t OP_LB  = 4'd0;
    localparam sinst_t OP_LH  = 4'd1;
    localparam sinst_t OP_LW  = 4'd2;
    localparam sinst_t OP_LBU = 4'd3;
    localparam sinst_t OP_LHU = 4'd4;
    localparam sinst_t OP_SB  = 4'd5;
    localparam sinst_t OP_SH  = 4'd6;
    localparam sinst_t OP_SW  = 4'd7;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCESS,
        S_WAIT,
        S_DONE
    } ls_state_e;

    // Unknown op codes fall through to word width.
    function automatic logic [2:0] ls_nbytes(input sinst_t op);
        logic [2:0] n;
        case (op)
            OP_LB, OP_LBU, OP_SB: n = 3'd1;
            OP_LH, OP_LHU, OP_SH: n = 3'd2;
            default:              n = 3'd4;
        endcase
        return n;
    endfunction

    function automatic logic ls_is_store(input sinst_t op);
        return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
    endfunction

    function automatic word_t ls_ext(input sinst_t op, input word_t raw);
        word_t w;
        case (op)
            OP_LB:   w = {{24{raw[7]}}, raw[7:0]};
            OP_LH:   w = {{16{raw[15]}}, raw[15:0]};
            OP_LBU:  w = {24'd0, raw[7:0]};
            OP_LHU:  w = {16'd0, raw[15:0]};
            default: w = raw;
        endcase
        return w;
    endfunction

endpackage

// File: rtl/ex_ls_extend.sv
// Combinational load extension and access width decode.
// Ports: op_i, raw_i -> ext_o (extended word), nbytes_o, is_store_o.
module ls_extend
    import ex_ls_pkg::*;
(
    input  sinst_t     op_i,
    input  word_t      raw_i,
    output word_t      ext_o,
    output logic [2:0] nbytes_o,
    output logic       is_store_o
);

    assign ext_o      = ls_ext(op_i, raw_i);
    assign nbytes_o   = ls_nbytes(op_i);
    assign is_store_o = ls_is_store(op_i);

endmodule

// File: rtl/ex_ls.sv
// Load/store execution unit: takes the LS reservation-station entry,
// performs a byte-serial access on the memory port and broadcasts the
// completion on the LS result bus (en_ls/busy_ls/ls_data/tags).
// Ports: clk, rst (async active-low), rdy, RS entry inputs (ls_*_in),
// result bus (en_ls, busy_ls, ls_data, ls_tag_out, ls_target_out),
// memory port (mem_a, mem_dout, mem_wr, mem_din).
// Macro LS_IO_STALL_EN adds io_buffer_full, which holds store bytes
// aimed at addresses >= IO_BASE.
module ex_ls
    import ex_ls_pkg::*;
#(
    parameter word_t IO_BASE = LS_IO_BASE
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic        ls_busy_in,
    input  sinst_t      ls_op_in,
    input  word_t       ls_offset_in,
    input  regtag_t     ls_tagx_in,
    input  regtag_t     ls_tagy_in,
    input  regtag_t     ls_tagw_in,
    input  word_t       ls_datax_in,
    input  word_t       ls_datay_in,
    input  regaddr_t    ls_target_in,
    output logic        en_ls,
    output logic        busy_ls,
    output word_t       ls_data,
    output regtag_t     ls_tag_out,
    output regaddr_t    ls_target_out,
    output logic [31:0] mem_a,
    output logic [7:0]  mem_dout,
    output logic        mem_wr,
`ifdef LS_IO_STALL_EN
    input  logic        io_buffer_full,
`endif
    input  logic [7:0]  mem_din
);

    ls_state_e  state_q;
    word_t      addr_q;
    sinst_t     op_q;
    word_t      datay_q;
    regtag_t    tagw_q;
    regaddr_t   target_q;
    logic [1:0] cnt_q;
    word_t      res_q;
    logic [1:0] pidx_q;
    logic       pv_q;

    logic       en_q;
    word_t      data_q;
    regtag_t    tag_q;
    regaddr_t   tgt_q;
    word_t      mem_a_q;
    logic [7:0] mem_dout_q;
    logic       mem_wr_q;

    word_t      raw;
    word_t      ext;
    logic [2:0] nb;
    logic       st_q;
    logic [1:0] lidx;
    logic [1:0] nxt;
    logic       last;
    logic       st_in;
    logic       opnd_rdy;
    word_t      ea;
    logic       io_full;
    logic       io_hold;

    ls_extend u_ext (
        .op_i       (op_q),
        .raw_i      (raw),
        .ext_o      (ext),
        .nbytes_o   (nb),
        .is_store_o (st_q)
    );

    assign st_in    = ls_is_store(ls_op_in);
    assign opnd_rdy = (ls_tagx_in == UNLOCKED) &&
                      (!st_in || (ls_tagy_in == UNLOCKED));
    assign ea       = ls_datax_in + ls_offset_in;
    assign lidx     = 2'(nb - 3'd1);
    assign nxt      = cnt_q + 2'd1;
    assign last     = (cnt_q == lidx);

`ifdef LS_IO_STALL_EN
    assign io_full = io_buffer_full;
`else
    assign io_full = 1'b0;
`endif

    assign io_hold = io_full && (state_q == S_ACCESS) && st_q &&
                     (mem_a_q >= IO_BASE);

    // The final load byte arrives in the WAIT cycle; merge it directly.
    always_comb begin
        raw = res_q;
        raw[lidx*8 +: 8] = mem_din;
    end

    assign busy_ls       = ls_busy_in & (state_q != S_DONE);
    assign en_ls         = en_q;
    assign ls_data       = data_q;
    assign ls_tag_out    = tag_q;
    assign ls_target_out = tgt_q;
    assign mem_a         = mem_a_q;
    assign mem_dout      = mem_dout_q;
    assign mem_wr        = mem_wr_q & rdy & ~io_hold;

    // mem_din always reflects the address driven one cycle earlier, and
    // mem_a only moves when the FSM advances. Tracking that pipeline
    // independently of rdy keeps load bytes correct across stalls.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pv_q   <= 1'b0;
            pidx_q <= 2'd0;
            res_q  <= '0;
        end else begin
            pv_q   <= (state_q == S_ACCESS) && !st_q;
            pidx_q <= cnt_q;
            if (pv_q) res_q[pidx_q*8 +: 8] <= mem_din;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            addr_q     <= '0;
            op_q       <= OP_LW;
            datay_q    <= '0;
            tagw_q     <= UNLOCKED;
            target_q   <= '0;
            cnt_q      <= 2'd0;
            en_q       <= 1'b0;
            data_q     <= '0;
            tag_q      <= UNLOCKED;
            tgt_q      <= '0;
            mem_a_q    <= '0;
            mem_dout_q <= '0;
            mem_wr_q   <= 1'b0;
        end else if (rdy) begin
            unique case (state_q)
                S_IDLE: begin
                    if (ls_busy_in && opnd_rdy) begin
                        addr_q     <= ea;
                        op_q       <= ls_op_in;
                        datay_q    <= ls_datay_in;
                        tagw_q     <= ls_tagw_in;
                        target_q   <= ls_target_in;
                        cnt_q      <= 2'd0;
                        mem_a_q    <= ea;
                        mem_dout_q <= ls_datay_in[7:0];
                        mem_wr_q   <= st_in;
                        state_q    <= S_ACCESS;
                    end
                end
                S_ACCESS: begin
                    if (!io_hold) begin
                        if (last) begin
                            mem_wr_q <= 1'b0;
                            if (st_q) begin
                                state_q <= S_DONE;
                                en_q    <= 1'b1;
                                data_q  <= '0;
                                tag_q   <= tagw_q;
                                tgt_q   <= '0;
                            end else begin
                                state_q <= S_WAIT;
                            end
                        end else begin
                            cnt_q      <= nxt;
                            mem_a_q    <= addr_q + {30'd0, nxt};
                            mem_dout_q <= datay_q[nxt*8 +: 8];
                        end
                    end
                end
                S_WAIT: begin
                    state_q <= S_DONE;
                    en_q    <= 1'b1;
                    data_q  <= ext;
                    tag_q   <= tagw_q;
                    tgt_q   <= target_q;
                end
                S_DONE: begin
                    en_q    <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: doc/ex_ls.md
Name: ex_ls

Overview:
- Load/store execution unit. Consumer end of the load/store reservation-station interface.
- Takes the single LS reservation-station entry once its operands are resolved. Computes the effective address and performs the access over the byte-wide memory port.
- Broadcasts the completion on the LS result bus (en_ls/busy_ls/ls_data). The reservation station and the other stations snoop that bus.

Parameters:
- IO_BASE, 32'h0003_0000, addresses at or above this are memory-mapped IO; the optional feature uses it.

Ports:
- clk  in  1  system clock; all state changes on posedge.
- rst  in  1  asynchronous, active-low reset.
- rdy  in  1  global ready; low freezes all state and forces mem_wr=0.
- ls_busy_in  in  1  RS entry valid.
- ls_op_in  in  `sinst_t  one of LB/LH/LW/LBU/LHU/SB/SH/SW.
- ls_offset_in  in  `word_t  sign-extended immediate.
- ls_tagx_in, ls_tagy_in  in  `regtag_t  operand tags; `UNLOCKED means data is valid.
- ls_tagw_in  in  `regtag_t  destination tag.
- ls_datax_in  in  `word_t  base register.
- ls_datay_in  in  `word_t  store data.
- ls_target_in  in  `regaddr_t  destination register.
- en_ls  out  1  one-cycle completion strobe.
- busy_ls  out  1  keep-busy to the RS.
- ls_data  out  `word_t  load result; 0 for stores.
- ls_tag_out  out  `regtag_t  tag being completed.
- ls_target_out  out  `regaddr_t  destination register; 0 for stores.
- mem_a  out  32  byte address.
- mem_dout  out  8  write byte.
- mem_wr  out  1  write strobe.
- mem_din  in  8  read byte; valid one cycle after mem_a.

Behaviour:
- Reset (rst=0, async): state IDLE, en_ls=0, ls_data=0, ls_tag_out=`UNLOCKED, ls_target_out=0, mem_a=0, mem_dout=0, mem_wr=0, counters cleared. Reset mid-access aborts it; a partially written store stays partial.
- busy_ls = ls_busy_in & ~(state==DONE). Combinational, so the RS frees its entry on the completion edge.
- Ready condition:
  - Load: tagx==`UNLOCKED.
  - Store: tagx==`UNLOCKED and tagy==`UNLOCKED.
- States:
  - IDLE -> ACCESS: on a posedge (cycle T) with ls_busy_in, operands ready, and rdy. At T, latch addr = datax+offset (mod 2^32), op, datay, tagw, target. Set byte count N: B=1, H=2, W=4.
  - ACCESS: at cycles T+1..T+N drive mem_a=addr+i (mod 2^32), i=0..N-1.
    - Store: mem_wr=1, mem_dout=datay[8i+7:8i] (little-endian).
    - Load: mem_wr=0.
    - After the last byte: store -> DONE; load -> WAIT.
  - Load byte capture: byte i is captured from mem_din at cycle T+2+i into result[8i+7:8i].
  - WAIT: one cycle for the final load byte; -> DONE.
  - DONE: en_ls=1 for exactly one cycle, ls_tag_out=tagw.
    - Load: ls_data is the result, sign-extended (LB/LH) or zero-extended (LBU/LHU); ls_target_out=target.
    - Store: ls_data=0, ls_target_out=0.
    - -> IDLE. No new accept in the DONE cycle.
- Latency accept->en_ls: load N+2 cycles; store N+1 cycles.
- RS inputs are ignored while not IDLE; all values used come from the latches taken at accept.
- rdy=0 in any state: hold state, counters and outputs; mem_wr forced 0. The byte in flight is re-issued when rdy returns.
- Misaligned addresses are legal (byte-serial access). Address wrap-around at 32'hFFFF_FFFF is legal.
- Illegal op code: treated as LW.

Optional Feature:
- Macro LS_IO_STALL_EN.
- Defined: adds input io_buffer_full (1 bit). While io_buffer_full=1, an ACCESS-cycle store byte whose address is ≥ IO_BASE is held: mem_wr=0, the counter does not advance, and the byte is retried each cycle.
- Undefined: the port is absent and IO stores proceed unconditionally.

Decomposition:
- Shared package: `sinst_t, `word_t, `regtag_t, `regaddr_t, `UNLOCKED, and the LS op encodings.
- Also in the package: a byte-count function and an extend function (op, raw) -> word.
- One sub-module: ls_extend. Combinational sign/zero extension plus byte count from op. It is shared with any future load-forwarding path.

Test Plan:
- LW, datax=32'h100, offset=4, mem[0x104..0x107]=78,56,34,12 -> mem_a=0x104..0x107 on T+1..T+4; en_ls at T+6; ls_data=32'h12345678; ls_tag_out=tagw.
- LB vs LBU at byte 0x80 -> ls_data=32'hFFFF_FF80 and 32'h0000_0080 respectively.
- SH, datay=32'hAABB_CCDD, addr=0x201 -> mem_wr=1 with (0x201,DD),(0x202,CC); en_ls at T+3; ls_data=0; ls_target_out=0.
- Entry valid with tagy≠`UNLOCKED (store) -> no memory activity and busy_ls=1 until the tag becomes `UNLOCKED; then accept.
- rdy low for 3 cycles mid-LW, and rst=0 mid-SW -> LW result is unchanged with completion delayed by 3 cycles. SW: mem_wr falls immediately; state IDLE, en_ls=0.
- LS_IO_STALL_EN: SB to 0x30000 with io_buffer_full=1 for 2 cycles -> mem_wr held 0 for 2 cycles; en_ls 2 cycles late.
